// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer for the 8-bit LEG-style core: fetches 4-byte instructions
// over a req/ack handshake, decodes operand/write-back enables and owns the PC.
module instr_sequencer #(
    parameter int DATA_W      = 8,
    parameter int STEP        = 4,
    parameter int COUNTER_REG = 6,
    parameter int INPUT_REG   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [DATA_W-1:0] memAddr,
    output logic              memReq,
    input  logic [DATA_W-1:0] memData,
    input  logic              memAck,
    input  logic              condTrue,
    input  logic [DATA_W-1:0] wbVal,
    output logic [DATA_W-1:0] opcode1,
    output logic [DATA_W-1:0] opcode2,
    output logic [DATA_W-1:0] opcode3,
    output logic [DATA_W-1:0] opcode4,
    output logic [DATA_W-1:0] cnt,
    output logic              imm1,
    output logic              imm2,
    output logic              counterEnable1,
    output logic              counterEnable2,
    output logic              inputEnable1,
    output logic              inputEnable2,
    output logic              counterEnable3,
    output logic              conditionEnable,
    output logic              execValid
);

    typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, EXEC} stateT;

    stateT             state;
    logic [DATA_W-1:0] nextCnt;

    // Decode is purely combinational from the latched bytes, qualified by EXEC
    always_comb begin
        execValid       = (state == EXEC);
        imm1            = execValid && opcode1[7];
        imm2            = execValid && opcode1[6];
        counterEnable1  = execValid && !opcode1[7] && (opcode2 == DATA_W'(COUNTER_REG));
        inputEnable1    = execValid && !opcode1[7] && (opcode2 == DATA_W'(INPUT_REG));
        counterEnable2  = execValid && !opcode1[6] && (opcode3 == DATA_W'(COUNTER_REG));
        inputEnable2    = execValid && !opcode1[6] && (opcode3 == DATA_W'(INPUT_REG));
        conditionEnable = execValid && opcode1[5] && condTrue;
        counterEnable3  = execValid && !opcode1[5] && (opcode4 == DATA_W'(COUNTER_REG));
    end

    // Jump target beats counter write-back, which beats sequential advance
    always_comb begin
        nextCnt = cnt + DATA_W'(STEP);
        if (conditionEnable)
            nextCnt = opcode4;
        else if (counterEnable3)
            nextCnt = wbVal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            memAddr <= '0;
            memReq  <= 1'b0;
            opcode1 <= '0;
            opcode2 <= '0;
            opcode3 <= '0;
            opcode4 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= F0;
                        memReq  <= 1'b1;
                        memAddr <= cnt;
                    end
                end
                F0: begin
                    if (memAck) begin
                        opcode1 <= memData;
                        memAddr <= cnt + DATA_W'(1);
                        state   <= F1;
                    end
                end
                F1: begin
                    if (memAck) begin
                        opcode2 <= memData;
                        memAddr <= cnt + DATA_W'(2);
                        state   <= F2;
                    end
                end
                F2: begin
                    if (memAck) begin
                        opcode3 <= memData;
                        memAddr <= cnt + DATA_W'(3);
                        state   <= F3;
                    end
                end
                F3: begin
                    if (memAck) begin
                        opcode4 <= memData;
                        memReq  <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= nextCnt;
                    if (run) begin
                        state   <= F0;
                        memReq  <= 1'b1;
                        memAddr <= nextCnt;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a byte-array program memory answers fetches,
// each scenario task checks its own hand-computed expectations.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] memAddr;
    logic       memReq;
    logic [7:0] memData;
    logic       memAck = 1'b0;
    logic       condTrue = 1'b0;
    logic [7:0] wbVal = 8'h00;
    logic [7:0] opcode1, opcode2, opcode3, opcode4, cnt;
    logic       imm1, imm2, counterEnable1, counterEnable2, inputEnable1, inputEnable2;
    logic       counterEnable3, conditionEnable, execValid;

    logic [7:0] mem [256];
    int         checks = 0;
    int         fails = 0;

    assign memData = mem[memAddr];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .memAddr(memAddr), .memReq(memReq), .memData(memData), .memAck(memAck),
        .condTrue(condTrue), .wbVal(wbVal),
        .opcode1(opcode1), .opcode2(opcode2), .opcode3(opcode3), .opcode4(opcode4),
        .cnt(cnt), .imm1(imm1), .imm2(imm2),
        .counterEnable1(counterEnable1), .counterEnable2(counterEnable2),
        .inputEnable1(inputEnable1), .inputEnable2(inputEnable2),
        .counterEnable3(counterEnable3), .conditionEnable(conditionEnable),
        .execValid(execValid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3,
                                 input logic [7:0] b4);
        mem[addr]        = b1;
        mem[addr + 8'd1] = b2;
        mem[addr + 8'd2] = b3;
        mem[addr + 8'd3] = b4;
    endtask

    task automatic waitExec(input string tag);
        for (int i = 0; i < 12 && !execValid; i++) step();
        if (!execValid) begin
            checks++; fails++;
            $display("[TB] FAIL %s_timeout: execValid got 0 want 1 within 12 cycles", tag);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0; run = 1'b0; memAck = 1'b0; condTrue = 1'b0; wbVal = 8'h00;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (cnt !== 8'h00) begin fails++; $display("[TB] FAIL reset_cnt: got %h want 00", cnt); end
        checks++; if (memReq !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b want 0", memReq); end
        checks++; if (memAddr !== 8'h00) begin fails++; $display("[TB] FAIL reset_addr: got %h want 00", memAddr); end
        checks++; if (execValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_exec: got %b want 0", execValid); end
        checks++; if (opcode1 !== 8'h00) begin fails++; $display("[TB] FAIL reset_op1: got %h want 00", opcode1); end
    endtask

    task automatic test_basic_fetch();
        run = 1'b1; memAck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (memAddr !== 8'(k) || memReq !== 1'b1) begin
                fails++;
                $display("[TB] FAIL fetch_addr%0d: got addr %h req %b want addr %h req 1", k, memAddr, memReq, 8'(k));
            end
        end
        step();
        checks++; if (execValid !== 1'b1) begin fails++; $display("[TB] FAIL basic_exec: got %b want 1", execValid); end
        checks++;
        if ({imm1, imm2, counterEnable1, counterEnable2, inputEnable1, inputEnable2,
             counterEnable3, conditionEnable} !== 8'h00) begin
            fails++;
            $display("[TB] FAIL basic_enables: got %b%b%b%b%b%b%b%b want all 0", imm1, imm2,
                     counterEnable1, counterEnable2, inputEnable1, inputEnable2, counterEnable3, conditionEnable);
        end
        checks++; if ({opcode1, opcode2, opcode3, opcode4} !== 32'h00010203) begin fails++; $display("[TB] FAIL basic_ops: got %h%h%h%h want 00010203", opcode1, opcode2, opcode3, opcode4); end
        checks++; if (memReq !== 1'b0) begin fails++; $display("[TB] FAIL basic_exec_req: got %b want 0", memReq); end
        step();
        checks++; if (cnt !== 8'h04) begin fails++; $display("[TB] FAIL basic_cnt: got %h want 04", cnt); end
        checks++; if (memAddr !== 8'h04 || memReq !== 1'b1) begin fails++; $display("[TB] FAIL basic_next_addr: got %h req %b want 04 req 1", memAddr, memReq); end
    endtask

    task automatic test_decode();
        waitExec("imm");
        checks++; if (imm1 !== 1'b1 || imm2 !== 1'b1) begin fails++; $display("[TB] FAIL imm_flags: got %b%b want 11", imm1, imm2); end
        checks++;
        if ({counterEnable1, counterEnable2, inputEnable1, inputEnable2, counterEnable3} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL imm_enables: got %b%b%b%b%b want 00000", counterEnable1, counterEnable2, inputEnable1, inputEnable2, counterEnable3);
        end
        step();
        checks++; if (cnt !== 8'h08) begin fails++; $display("[TB] FAIL imm_cnt: got %h want 08", cnt); end
        waitExec("reg_src");
        checks++; if (counterEnable1 !== 1'b1) begin fails++; $display("[TB] FAIL reg_ce1: got %b want 1", counterEnable1); end
        checks++; if (inputEnable2 !== 1'b1) begin fails++; $display("[TB] FAIL reg_ie2: got %b want 1", inputEnable2); end
        checks++;
        if ({inputEnable1, counterEnable2, counterEnable3, imm1, imm2} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reg_others: got %b%b%b%b%b want 00000", inputEnable1, counterEnable2, counterEnable3, imm1, imm2);
        end
        step();
        checks++; if (counterEnable1 !== 1'b0 || inputEnable2 !== 1'b0) begin fails++; $display("[TB] FAIL reg_gated: got ce1 %b ie2 %b want 0 0", counterEnable1, inputEnable2); end
        checks++; if (cnt !== 8'h0C) begin fails++; $display("[TB] FAIL reg_cnt: got %h want 0c", cnt); end
    endtask

    task automatic test_cond_jump();
        condTrue = 1'b1;
        waitExec("jmp_taken");
        checks++; if (conditionEnable !== 1'b1) begin fails++; $display("[TB] FAIL jmp_taken_en: got %b want 1", conditionEnable); end
        step();
        checks++; if (cnt !== 8'h40) begin fails++; $display("[TB] FAIL jmp_taken_cnt: got %h want 40", cnt); end
        condTrue = 1'b0;
        waitExec("jmp_not");
        checks++; if (conditionEnable !== 1'b0) begin fails++; $display("[TB] FAIL jmp_not_en: got %b want 0", conditionEnable); end
        step();
        checks++; if (cnt !== 8'h44) begin fails++; $display("[TB] FAIL jmp_not_cnt: got %h want 44", cnt); end
    endtask

    task automatic test_counter_wb();
        wbVal = 8'h80;
        waitExec("wb");
        checks++; if (counterEnable3 !== 1'b1 || conditionEnable !== 1'b0) begin fails++; $display("[TB] FAIL wb_en: got ce3 %b cond %b want 1 0", counterEnable3, conditionEnable); end
        step();
        checks++; if (cnt !== 8'h80) begin fails++; $display("[TB] FAIL wb_cnt: got %h want 80", cnt); end
        condTrue = 1'b1;
        waitExec("jmp_fc");
        step();
        checks++; if (cnt !== 8'hFC) begin fails++; $display("[TB] FAIL jmp_fc_cnt: got %h want fc", cnt); end
        condTrue = 1'b0;
        waitExec("wrap_pc");
        checks++; if (counterEnable3 !== 1'b0) begin fails++; $display("[TB] FAIL wrap_pc_ce3: got %b want 0", counterEnable3); end
        step();
        checks++; if (cnt !== 8'h00 || memAddr !== 8'h00) begin fails++; $display("[TB] FAIL wrap_pc_cnt: got cnt %h addr %h want 00 00", cnt, memAddr); end
    endtask

    task automatic test_wrap_fetch();
        logic [7:0] expAddr [4];
        expAddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        doReset();
        applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h06);
        applyStimulus(8'hFE, 8'h00, 8'h00, 8'h00, 8'h00);
        wbVal = 8'hFE; run = 1'b1; memAck = 1'b1;
        waitExec("wrap_setup");
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (memAddr !== expAddr[k]) begin
                fails++;
                $display("[TB] FAIL wrap_addr%0d: got %h want %h", k, memAddr, expAddr[k]);
            end
        end
        waitExec("wrap_exec");
        step();
        checks++; if (cnt !== 8'h02) begin fails++; $display("[TB] FAIL wrap_cnt: got %h want 02", cnt); end
    endtask

    task automatic test_ack_stall();
        doReset();
        applyStimulus(8'h00, 8'h00, 8'h11, 8'h22, 8'h33);
        run = 1'b1; memAck = 1'b1;
        step(); step(); step();
        memAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (memAddr !== 8'h02 || memReq !== 1'b1 || execValid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stall_hold%0d: got addr %h req %b exec %b want 02 1 0", k, memAddr, memReq, execValid);
            end
        end
        memAck = 1'b1;
        step();
        checks++; if (memAddr !== 8'h03) begin fails++; $display("[TB] FAIL stall_resume: got %h want 03", memAddr); end
        run = 1'b0;
        step();
        checks++; if (execValid !== 1'b1 || opcode3 !== 8'h22 || opcode4 !== 8'h33) begin fails++; $display("[TB] FAIL stall_exec: got exec %b op3 %h op4 %h want 1 22 33", execValid, opcode3, opcode4); end
    endtask

    task automatic test_reset_mid_fetch();
        doReset();
        run = 1'b1; memAck = 1'b1;
        waitExec("mid_setup");
        step();
        checks++; if (cnt !== 8'h04) begin fails++; $display("[TB] FAIL mid_pre_cnt: got %h want 04", cnt); end
        step(); step();
        rst_n = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (cnt !== 8'h00 || memReq !== 1'b0 || memAddr !== 8'h00 || opcode1 !== 8'h00) begin
            fails++;
            $display("[TB] FAIL mid_reset: got cnt %h req %b addr %h op1 %h want 00 0 00 00", cnt, memReq, memAddr, opcode1);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (memReq !== 1'b0 || execValid !== 1'b0) begin fails++; $display("[TB] FAIL mid_idle: got req %b exec %b want 0 0", memReq, execValid); end
    endtask

    task automatic test_run_drop();
        run = 1'b1; memAck = 1'b1;
        step(); step();
        run = 1'b0;
        waitExec("drop");
        checks++; if (opcode2 !== 8'h11) begin fails++; $display("[TB] FAIL drop_op2: got %h want 11", opcode2); end
        step();
        checks++; if (memReq !== 1'b0 || cnt !== 8'h04) begin fails++; $display("[TB] FAIL drop_idle: got req %b cnt %h want 0 04", memReq, cnt); end
        step();
        checks++; if (memReq !== 1'b0 || execValid !== 1'b0 || cnt !== 8'h04) begin fails++; $display("[TB] FAIL drop_stay: got req %b exec %b cnt %h want 0 0 04", memReq, execValid, cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        applyStimulus(8'h00, 8'h00, 8'h01, 8'h02, 8'h03);
        applyStimulus(8'h04, 8'hC0, 8'h05, 8'h07, 8'h02);
        applyStimulus(8'h08, 8'h00, 8'h06, 8'h07, 8'h03);
        applyStimulus(8'h0C, 8'h20, 8'h00, 8'h00, 8'h40);
        applyStimulus(8'h40, 8'h20, 8'h00, 8'h00, 8'h40);
        applyStimulus(8'h44, 8'h00, 8'h00, 8'h00, 8'h06);
        applyStimulus(8'h80, 8'h20, 8'h00, 8'h00, 8'hFC);
        test_reset();
        test_basic_fetch();
        test_decode();
        test_cond_jump();
        test_counter_wb();
        test_wrap_fetch();
        test_ack_stall();
        test_reset_mid_fetch();
        test_run_drop();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
